dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data memory (dmem, 128 x 32-bit words) between two requesters: port 0 = CPU load/store unit, port 1 = debug/DMA master (memory dump, preload).
- Sits between the requesters and the dmem array.
- Round-robin arbitration with an optional bus lock for bursts.
- Synchronous-read memory interface with 1-cycle read latency; read data is routed back to the requester that issued the read.

Parameters:
- ADDR_W, 7, word-address width (depth = 2**ADDR_W = 128).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- m0_req  in  1  port 0 request, held until granted.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_lock  in  1  port 0 keeps ownership after this grant.
- m0_addr  in  ADDR_W  port 0 word address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  port 0 request accepted this cycle.
- m0_rvalid  out  1  port 0 read data valid.
- m0_rdata  out  DATA_W  port 0 read data.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read strobe.

Behaviour:
- Reset values:
  - all gnt, rvalid, mem_en and mem_we = 0.
  - rdata, mem_addr and mem_wdata = 0.
  - RR pointer = port 0 (port 0 wins the first tie).
  - FSM = IDLE.
- Grant is combinational from req and state:
  - at most one gnt per cycle;
  - a request is accepted in the cycle its gnt=1;
  - mem_en/we/addr/wdata are driven combinationally from the granted port in that same cycle.
- Handshake: a requester holds req, we, addr, wdata and lock stable until gnt. A req deasserted before gnt is legal and is simply dropped.
- Read return: rvalid pulses on the granted port exactly 1 cycle after the read grant, with rdata = mem_rdata. The owner tag is registered so reads back-to-back on alternating ports return to the correct port. Writes produce no rvalid.
- FSM states:
  - IDLE: arbitration each cycle.
    - Only one req → grant it.
    - Both req → grant the port the RR pointer names, then the pointer moves to the other port.
    - Granted with lock=1 → go to OWN0 / OWN1.
  - OWN0 / OWN1: only the owning port may be granted. The other port's req is stalled (gnt=0).
    - Return to IDLE on the first owner grant with lock=0.
    - Also return to IDLE when the owner holds req=0 for LOCK_TMO=16 consecutive cycles. Timeout counter is 5-bit, clears on any owner grant.
    - On exit the RR pointer points to the non-owner.
- Simultaneous events:
  - A read rvalid returning in the same cycle as a new grant is legal; full throughput is 1 access/cycle.
  - Write followed by read of the same address on the next grant returns the new data (memory ordering is in issue order).
- Address wrap: none; addresses are ADDR_W bits, so 127 is the last word.
- Reset mid-operation:
  - pending rvalid is discarded (no rvalid after rst);
  - lock is released;
  - FSM goes to IDLE.

Optional Feature:
- DMEM_ARB_PERF_EN defined: adds
  - 16-bit saturating counters grant_cnt0, grant_cnt1 (count gnt pulses per port);
  - stall_cnt (cycles with req=1 and gnt=0, either port);
  - outputs grant_cnt0/grant_cnt1/stall_cnt (16 bits each);
  - all counters cleared by rst, saturating at 16'hFFFF.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - FSM state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - LOCK_TMO=16;
  - PORT0/PORT1 index constants.
- One sub-module, dmem_arb_rr: the 2-way round-robin pick plus pointer register. The top holds the FSM, lock timeout, read-return tag and muxing.

Test Plan:
- rst held 2 cycles, then released → all outputs 0; m0 read addr 5 → m0_gnt same cycle, m0_rvalid next cycle with dmem[5].
- m0 and m1 both request continuously (reads of addr 1 and 2) → gnt alternates 0,1,0,1; each rvalid lands on the correct port with dmem[1] / dmem[2].
- m1 write addr 10 = 32'hDEADBEEF with lock=1, then m0 req → m0 stalled; m1 lock=0 read addr 10 → rvalid with 32'hDEADBEEF; m0 granted on the next cycle.
- m0 lock=1 grant then m0_req=0 for 16 cycles while m1_req=1 → m1_gnt asserts in cycle 17 after the lock grant.
- Read grant issued, rst asserted the next cycle → no rvalid observed; FSM in IDLE; the next tie goes to port 0.
- DMEM_ARB_PERF_EN: 70000 m0 grants → grant_cnt0 = 16'hFFFF (saturated); stall_cnt equals the number of counted stall cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter: FSM encoding, lock timeout,
// port indices and the saturating-increment helper used by the optional counters.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;

    localparam int LOCK_TMO = 16;
    localparam int TMO_W    = 5;
    localparam int PERF_W   = 16;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the dmem arbiter: request/command from the master,
// grant and read return from the arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick with its pointer register. The pointer only moves on
// a tie, or when the owner FSM forces it to the non-owner after a lock ends.
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic load_i,
    input  logic load_port_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic ptr_q;
    logic ptr_d;
    logic tie;

    assign tie = en_i & req0_i & req1_i;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (en_i) begin
            if (tie) begin
                gnt0_o = (ptr_q == PORT0);
                gnt1_o = (ptr_q == PORT1);
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_port_i;
        end else if (tie) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read dmem between two requesters with
// round-robin arbitration and a burst lock. Build option DMEM_ARB_PERF_EN adds counters.
//   state | meaning
//   IDLE  | round-robin arbitration between both ports
//   OWN0  | port 0 holds the lock; port 1 is stalled
//   OWN1  | port 1 holds the lock; port 0 is stalled
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] grant_cnt0_o,
    output logic [PERF_W-1:0] grant_cnt1_o,
    output logic [PERF_W-1:0] stall_cnt_o
`endif
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;
    logic             rv0_q;
    logic             rv0_d;
    logic             rv1_q;
    logic             rv1_d;

    logic rr_en;
    logic rr_gnt0;
    logic rr_gnt1;
    logic rr_load;
    logic rr_load_port;
    logic gnt0;
    logic gnt1;
    logic rv0_out;
    logic rv1_out;
    logic own_port;
    logic own_req;
    logic own_lock;

    assign rr_en = ~rst & (state_q == IDLE);

    dmem_arb_rr u_rr (
        .clk         (clk),
        .rst         (rst),
        .en_i        (rr_en),
        .req0_i      (m0.req),
        .req1_i      (m1.req),
        .load_i      (rr_load),
        .load_port_i (rr_load_port),
        .gnt0_o      (rr_gnt0),
        .gnt1_o      (rr_gnt1)
    );

    assign own_port = (state_q == OWN1) ? PORT1 : PORT0;
    assign own_req  = own_port ? m1.req  : m0.req;
    assign own_lock = own_port ? m1.lock : m0.lock;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    gnt0 = rr_gnt0;
                    gnt1 = rr_gnt1;
                end
                OWN0:    gnt0 = m0.req;
                OWN1:    gnt1 = m1.req;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en_o    = gnt0 | gnt1;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt0) begin
            mem_we_o    = m0.we;
            mem_addr_o  = m0.addr;
            mem_wdata_o = m0.wdata;
        end else if (gnt1) begin
            mem_we_o    = m1.we;
            mem_addr_o  = m1.addr;
            mem_wdata_o = m1.wdata;
        end
    end

    // While locked, any owner request is granted, so own_req doubles as the owner grant.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        rr_load      = 1'b0;
        rr_load_port = PORT0;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (gnt0 && m0.lock) begin
                    state_d = OWN0;
                end else if (gnt1 && m1.lock) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (own_req) begin
                    tmo_d = '0;
                    if (!own_lock) begin
                        state_d      = IDLE;
                        rr_load      = 1'b1;
                        rr_load_port = ~own_port;
                    end
                end else if (tmo_q == TMO_W'(LOCK_TMO - 1)) begin
                    tmo_d        = '0;
                    state_d      = IDLE;
                    rr_load      = 1'b1;
                    rr_load_port = ~own_port;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    assign rv0_d = gnt0 & ~m0.we;
    assign rv1_d = gnt1 & ~m1.we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

    // A read granted just before reset must not surface while reset is held.
    assign rv0_out = rv0_q & ~rst;
    assign rv1_out = rv1_q & ~rst;

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rv0_out;
    assign m1.rvalid = rv1_out;
    assign m0.rdata  = rv0_out ? mem_rdata_i : '0;
    assign m1.rdata  = rv1_out ? mem_rdata_i : '0;

`ifdef DMEM_ARB_PERF_EN
    logic [PERF_W-1:0] gc0_q;
    logic [PERF_W-1:0] gc1_q;
    logic [PERF_W-1:0] stall_q;
    logic              stall;

    assign stall = (m0.req & ~gnt0) | (m1.req & ~gnt1);

    always_ff @(posedge clk) begin
        if (rst) begin
            gc0_q   <= '0;
            gc1_q   <= '0;
            stall_q <= '0;
        end else begin
            if (gnt0)  gc0_q   <= sat_inc(gc0_q);
            if (gnt1)  gc1_q   <= sat_inc(gc1_q);
            if (stall) stall_q <= sat_inc(stall_q);
        end
    end

    assign grant_cnt0_o = gc0_q;
    assign grant_cnt1_o = gc1_q;
    assign stall_cnt_o  = stall_q;
`endif

endmodule
